// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit add/subtract unit that reuses one CHUNK-bit ripple slice,
// LSB chunk first, with a start/busy/done handshake and a signed-overflow flag.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_s;
    logic             slice_c;
    logic             slice_c_msb;
    logic             accept;
    logic             last;

    assign accept  = start && ((state == IDLE) || (state == DONE));
    assign last    = (idx == LAST_IDX);
    assign slice_a = a_r[idx*CHUNK +: CHUNK];
    assign slice_b = b_r[idx*CHUNK +: CHUNK];

    // Ripple slice; slice_c_msb keeps the carry entering the slice's top bit,
    // which on the last chunk is the carry into the word's MSB.
    always_comb begin : slice_ripple
        logic c;
        // NOTE: every output gets a default before the loop so no latch is inferred.
        c           = carry;
        slice_c_msb = carry;
        slice_s     = '0;
        for (int j = 0; j < CHUNK; j++) begin
            slice_c_msb = c;
            slice_s[j]  = slice_a[j] ^ slice_b[j] ^ c;
            c           = (slice_a[j] & slice_b[j]) | (c & (slice_a[j] ^ slice_b[j]));
        end
        slice_c = c;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking updates so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                // Subtraction is a + ~b + ~borrow.
                a_r   <= a;
                b_r   <= sub ? ~b : b;
                carry <= sub ? ~cin : cin;
                idx   <= '0;
                sum   <= '0;
                cout  <= 1'b0;
                ovf   <= 1'b0;
            end else if (state == RUN) begin
                sum[idx*CHUNK +: CHUNK] <= slice_s;
                carry                   <= slice_c;
                if (last) begin
                    idx  <= '0;
                    cout <= slice_c;
                    ovf  <= slice_c_msb ^ slice_c;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Self-checking bench for chunked_adder: directed corner cases plus random operations
// compared against an integer-arithmetic reference, on a 16/4 and an 8/8 instance.
module tb_chunked_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16, sub16, cin16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    logic        start8, sub8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    int          n_checks = 0;
    int          n_fails  = 0;

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    chunked_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer result, wrapped modulo 2^w; overflow when the
    // signed interpretation of the exact result leaves the signed range.
    function automatic void model(input int w, input longint ta, input longint tb_,
                                  input bit tc, input bit ts,
                                  output longint es, output bit ec, output bit eo);
        longint mx, full, sa, sb, sres;
        mx   = longint'(1) << w;
        full = ts ? ta - tb_ - longint'(tc) : ta + tb_ + longint'(tc);
        ec   = ts ? (full >= 0) : (full >= mx);
        es   = ((full % mx) + mx) % mx;
        sa   = (ta >= mx / 2) ? ta - mx : ta;
        sb   = (tb_ >= mx / 2) ? tb_ - mx : tb_;
        sres = ts ? sa - sb - longint'(tc) : sa + sb + longint'(tc);
        eo   = (sres < -(mx / 2)) || (sres >= mx / 2);
    endfunction

    task automatic drive16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc, input logic ts);
        a16 = ta; b16 = tb_; cin16 = tc; sub16 = ts; start16 = 1'b1;
    endtask

    task automatic scramble16();
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
    endtask

    task automatic check_res16(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                               input logic tc, input logic ts);
        longint es;
        bit     ec, eo;
        model(16, longint'(ta), longint'(tb_), tc, ts, es, ec, eo);
        check({tag, "/sum"}, 32'(sum16), 32'(es));
        check({tag, "/cout"}, 32'(cout16), 32'(ec));
        check({tag, "/ovf"}, 32'(ovf16), 32'(eo));
    endtask

    // Called one cycle after the accepting edge; lat counts cycles since the start-high cycle.
    task automatic wait_done16(input int lat0, output int lat, output int nbusy);
        lat   = lat0;
        nbusy = 0;
        while (done16 !== 1'b1 && lat < 40) begin
            if (busy16 === 1'b1) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op16(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic ts);
        int lat, nb;
        @(negedge clk);
        drive16(ta, tb_, tc, ts);
        @(negedge clk);
        start16 = 1'b0;
        scramble16();
        check({tag, "/busy"}, 32'(busy16), 32'd1);
        check({tag, "/sumclr"}, 32'(sum16), 32'd0);
        wait_done16(1, lat, nb);
        check({tag, "/latency"}, 32'(lat), 32'd5);
        check({tag, "/busycycles"}, 32'(nb), 32'd4);
        check_res16(tag, ta, tb_, tc, ts);
        @(negedge clk);
        check({tag, "/donepulse"}, 32'(done16), 32'd0);
        check_res16({tag, "/held"}, ta, tb_, tc, ts);
    endtask

    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc, input logic ts);
        longint es;
        bit     ec, eo;
        int     lat;
        model(8, longint'(ta), longint'(tb_), tc, ts, es, ec, eo);
        @(negedge clk);
        a8 = ta; b8 = tb_; cin8 = tc; sub8 = ts; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        check({tag, "/busy"}, 32'(busy8), 32'd1);
        lat = 1;
        while (done8 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'd2);
        check({tag, "/sum"}, 32'(sum8), 32'(es));
        check({tag, "/cout"}, 32'(cout8), 32'(ec));
        check({tag, "/ovf"}, 32'(ovf8), 32'(eo));
        @(negedge clk);
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int lat, nb, ndone;
        logic [15:0] ra, rb;
        logic        rc, rs;

        // Reset with start held high: reset must win.
        rst = 1'b1;
        a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        repeat (2) @(negedge clk);
        check("reset/busy", 32'(busy16), 32'd0);
        check("reset/done", 32'(done16), 32'd0);
        check("reset/sum", 32'(sum16), 32'd0);
        check("reset/cout", 32'(cout16), 32'd0);
        check("reset/ovf", 32'(ovf16), 32'd0);
        check("reset/busy8", 32'(busy8), 32'd0);
        rst = 1'b0;
        start16 = 1'b0;
        start8  = 1'b0;

        op16("t1 ffff+1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op16("t2 7fff+1", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op16("t2 1234+4321+1", 16'h1234, 16'h4321, 1'b1, 1'b0);
        op16("t3 5-7", 16'h0005, 16'h0007, 1'b0, 1'b1);
        op16("t3 8000-1", 16'h8000, 16'h0001, 1'b0, 1'b1);

        // Start during RUN is ignored.
        @(negedge clk);
        drive16(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        drive16(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        @(negedge clk);
        start16 = 1'b0;
        wait_done16(3, lat, nb);
        check("t4 ignore/latency", 32'(lat), 32'd5);
        check_res16("t4 ignore", 16'h1111, 16'h2222, 1'b0, 1'b0);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done16 === 1'b1) ndone++;
        end
        check("t4 ignore/extra done", 32'(ndone), 32'd0);
        check("t4 ignore/idle busy", 32'(busy16), 32'd0);

        // Back-to-back: start asserted in the DONE cycle.
        @(negedge clk);
        drive16(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        @(negedge clk);
        start16 = 1'b0;
        wait_done16(1, lat, nb);
        check("t4 b2b first/latency", 32'(lat), 32'd5);
        check_res16("t4 b2b first", 16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        drive16(16'hABCD, 16'h1234, 1'b1, 1'b1);
        @(negedge clk);
        start16 = 1'b0;
        check("t4 b2b second/sumclr", 32'(sum16), 32'd0);
        wait_done16(1, lat, nb);
        check("t4 b2b second/latency", 32'(lat), 32'd5);
        check_res16("t4 b2b second", 16'hABCD, 16'h1234, 1'b1, 1'b1);
        @(negedge clk);

        // Reset in the second RUN cycle aborts the operation.
        @(negedge clk);
        drive16(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5 abort/busy", 32'(busy16), 32'd0);
        check("t5 abort/done", 32'(done16), 32'd0);
        check("t5 abort/sum", 32'(sum16), 32'd0);
        check("t5 abort/cout", 32'(cout16), 32'd0);
        check("t5 abort/ovf", 32'(ovf16), 32'd0);
        rst = 1'b0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done16 === 1'b1) ndone++;
        end
        check("t5 abort/late done", 32'(ndone), 32'd0);

        for (int i = 0; i < 30; i++) begin
            ra = pick16();
            rb = pick16();
            rc = 1'($urandom);
            rs = 1'($urandom);
            op16($sformatf("rand16 #%0d", i), ra, rb, rc, rs);
        end

        op8("t6 ff+ff+1", 8'hFF, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            op8($sformatf("rand8 #%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
